// File: rtl/count_checker.sv
// Receive-side monitor for an up-counter bus: acquires lock on the incrementing
// sequence, then flags out-of-sequence samples and counts errors and wraps.
module count_checker #(
  parameter int WIDTH       = 4,
  parameter int LOCK_COUNT  = 3,
  parameter int UNLOCK_ERRS = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] q_i,
  input  logic             valid_i,
  output logic             locked_o,
  output logic             err_o,
  output logic             wrap_o,
  output logic [WIDTH-1:0] expected_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] wrap_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [3:0]       good_q, good_d;
  logic [3:0]       bad_q, bad_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;
  logic             locked_q, locked_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

  logic             match;
  logic [3:0]       good_inc;
  logic [3:0]       bad_inc;

  // Increment comparison wraps naturally, so max followed by 0 is in sequence.
  assign match    = (q_i == prev_q + WIDTH'(1));
  assign good_inc = good_q + 4'd1;
  assign bad_inc  = bad_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    good_d     = good_q;
    bad_d      = bad_q;
    err_d      = 1'b0;
    wrap_d     = 1'b0;
    err_cnt_d  = err_cnt_q;
    wrap_cnt_d = wrap_cnt_q;

    if (valid_i) begin
      prev_d = q_i;
      unique case (state_q)
        IDLE: begin
          good_d  = 4'd0;
          state_d = ACQ;
        end
        ACQ: begin
          if (match) begin
            good_d = good_inc;
            if (good_inc == 4'(LOCK_COUNT)) begin
              state_d = LOCKED;
              bad_d   = 4'd0;
            end
          end else begin
            good_d = 4'd0;
          end
        end
        LOCKED: begin
          if (match) begin
            bad_d = 4'd0;
            if (q_i == '0) begin
              wrap_d     = 1'b1;
              wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
            end
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            bad_d = bad_inc;
            if (bad_inc == 4'(UNLOCK_ERRS)) begin
              state_d = ACQ;
              good_d  = 4'd0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    locked_d   = (state_d == LOCKED);
    expected_d = (state_d == IDLE) ? '0 : prev_d + WIDTH'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      good_q     <= 4'd0;
      bad_q      <= 4'd0;
      err_q      <= 1'b0;
      wrap_q     <= 1'b0;
      locked_q   <= 1'b0;
      expected_q <= '0;
      err_cnt_q  <= '0;
      wrap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      err_q      <= err_d;
      wrap_q     <= wrap_d;
      locked_q   <= locked_d;
      expected_q <= expected_d;
      err_cnt_q  <= err_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign locked_o   = locked_q;
  assign err_o      = err_q;
  assign wrap_o     = wrap_q;
  assign expected_o = expected_q;
  assign err_cnt_o  = err_cnt_q;
  assign wrap_cnt_o = wrap_cnt_q;

endmodule

// File: tb/tb_count_checker.sv
// Self-checking bench for count_checker: table-driven lock/wrap/error vectors,
// then a model-driven run that saturates the error counter, then async reset.
module tb_count_checker;

  typedef struct {
    logic       v;
    logic [3:0] q;
    logic       lk;
    logic       er;
    logic       wr;
    logic [3:0] ex;
    logic [7:0] ec;
    logic [7:0] wc;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] q;
  logic       valid;
  logic       locked;
  logic       err;
  logic       wrap;
  logic [3:0] expected;
  logic [7:0] err_cnt;
  logic [7:0] wrap_cnt;

  int checks   = 0;
  int failures = 0;
  int stepNo   = 0;

  vec_t tbl[$];
  vec_t sb[$];

  // Reference model state (used after the second reset)
  int mSt, mPrev, mGood, mBad, mEc, mWc;

  count_checker #(
    .WIDTH(4), .LOCK_COUNT(3), .UNLOCK_ERRS(2), .CNT_W(8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .q_i        (q),
    .valid_i    (valid),
    .locked_o   (locked),
    .err_o      (err),
    .wrap_o     (wrap),
    .expected_o (expected),
    .err_cnt_o  (err_cnt),
    .wrap_cnt_o (wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic v, logic [3:0] qq, logic lk, logic er, logic wr,
                              logic [3:0] ex, logic [7:0] ec, logic [7:0] wc);
    vec_t r;
    r.v = v; r.q = qq; r.lk = lk; r.er = er; r.wr = wr; r.ex = ex; r.ec = ec; r.wc = wc;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mSt = 0; mPrev = 0; mGood = 0; mBad = 0; mEc = 0; mWc = 0;
  endtask

  function automatic vec_t modelStep(logic v, logic [3:0] qq);
    vec_t r;
    int qi;
    bit isMatch;
    qi = int'(qq);
    r = mk(v, qq, 0, 0, 0, 0, 0, 0);
    if (v) begin
      isMatch = (qi == ((mPrev + 1) % 16));
      if (mSt == 0) begin
        mGood = 0; mSt = 1;
      end else if (mSt == 1) begin
        if (isMatch) begin
          mGood = mGood + 1;
          if (mGood == 3) begin mSt = 2; mBad = 0; end
        end else mGood = 0;
      end else begin
        if (isMatch) begin
          mBad = 0;
          if (qi == 0) begin r.wr = 1; mWc = (mWc + 1) % 256; end
        end else begin
          r.er = 1;
          if (mEc < 255) mEc = mEc + 1;
          mBad = mBad + 1;
          if (mBad == 2) begin mSt = 1; mGood = 0; end
        end
      end
      mPrev = qi;
    end
    r.lk = (mSt == 2);
    r.ex = (mSt == 0) ? 4'd0 : 4'((mPrev + 1) % 16);
    r.ec = 8'(mEc);
    r.wc = 8'(mWc);
    return r;
  endfunction

  task automatic applyStimulus(input vec_t e);
    @(negedge clk);
    valid = e.v;
    q     = e.q;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkOutput();
    vec_t e;
    string tag;
    e = sb.pop_front();
    stepNo++;
    tag = $sformatf("step%0d", stepNo);
    chk({tag, "_locked"},   int'(locked),   int'(e.lk));
    chk({tag, "_err"},      int'(err),      int'(e.er));
    chk({tag, "_wrap"},     int'(wrap),     int'(e.wr));
    chk({tag, "_expected"}, int'(expected), int'(e.ex));
    chk({tag, "_err_cnt"},  int'(err_cnt),  int'(e.ec));
    chk({tag, "_wrap_cnt"}, int'(wrap_cnt), int'(e.wc));
  endtask

  task automatic checkAllZero(input string name);
    chk({name, "_locked"},   int'(locked),   0);
    chk({name, "_err"},      int'(err),      0);
    chk({name, "_wrap"},     int'(wrap),     0);
    chk({name, "_expected"}, int'(expected), 0);
    chk({name, "_err_cnt"},  int'(err_cnt),  0);
    chk({name, "_wrap_cnt"}, int'(wrap_cnt), 0);
  endtask

  initial begin
    int p;
    rst_n = 1'b0;
    valid = 1'b0;
    q     = 4'd0;
    #1;
    checkAllZero("reset");

    // Acquisition on 5,6,7,8, then run through a wrap
    tbl.push_back(mk(1, 5, 0, 0, 0, 6, 0, 0));
    tbl.push_back(mk(1, 6, 0, 0, 0, 7, 0, 0));
    tbl.push_back(mk(1, 7, 0, 0, 0, 8, 0, 0));
    tbl.push_back(mk(1, 8, 1, 0, 0, 9, 0, 0));
    for (int i = 9; i <= 14; i++) tbl.push_back(mk(1, 4'(i), 1, 0, 0, 4'(i + 1), 0, 0));
    tbl.push_back(mk(1, 15, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0,  1, 0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 1,  1, 0, 0, 2, 0, 1));
    for (int i = 2; i <= 8; i++) tbl.push_back(mk(1, 4'(i), 1, 0, 0, 4'(i + 1), 0, 1));
    // Single error then resync to the observed value
    tbl.push_back(mk(1, 3, 1, 1, 0, 4, 1, 1));
    tbl.push_back(mk(1, 4, 1, 0, 0, 5, 1, 1));
    for (int i = 5; i <= 8; i++) tbl.push_back(mk(1, 4'(i), 1, 0, 0, 4'(i + 1), 1, 1));
    // Two consecutive errors drop lock, then re-acquire
    tbl.push_back(mk(1, 3,  1, 1, 0, 4,  2, 1));
    tbl.push_back(mk(1, 9,  0, 1, 0, 10, 3, 1));
    tbl.push_back(mk(1, 10, 0, 0, 0, 11, 3, 1));
    tbl.push_back(mk(1, 11, 0, 0, 0, 12, 3, 1));
    tbl.push_back(mk(1, 12, 1, 0, 0, 13, 3, 1));
    // VALID low with garbage on the bus: everything holds
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 4'($urandom_range(0, 15)), 1, 0, 0, 13, 3, 1));
    tbl.push_back(mk(1, 13, 1, 0, 0, 14, 3, 1));

    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) applyStimulus(tbl[i]);

    // Fresh start; model-predicted lock/err rounds until ERR_CNT saturates
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkAllZero("reset2");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    p = 0;
    applyStimulus(modelStep(1, 4'(p)));
    for (int r = 0; r < 130; r++) begin
      for (int k = 0; k < 3; k++) begin
        p = (p + 1) % 16;
        applyStimulus(modelStep(1, 4'(p)));
      end
      for (int k = 0; k < 2; k++) begin
        p = (p + 2) % 16;
        applyStimulus(modelStep(1, 4'(p)));
      end
    end
    chk("err_cnt_saturated", int'(err_cnt), 255);

    // Asynchronous reset between edges clears outputs without a clock
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mk(1, 7, 0, 0, 0, 8, 0, 0));
    applyStimulus(mk(1, 8, 0, 0, 0, 9, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
